// File: rtl/oled_text_arbiter_if.sv
// Request/response bundle between the two character writers, the arbiter and the
// oled command port.
interface oled_text_arbiter_if;
    logic [1:0]  req_valid;     // per-requester write request, held until acked
    logic [13:0] req_addr;      // {addr1[6:0], addr0[6:0]}
    logic [15:0] req_char;      // {char1, char0}
    logic [1:0]  req_ack;       // one-cycle accept pulse
    logic        clear_req;     // pulse: queue a display clear
    logic        oled_ready;
    logic [8:0]  oled_command;  // {rs, db[7:0]}
    logic        oled_strobe;
    logic        oled_wait;
    logic        init_done;
    logic        busy;

    // Arbiter side
    modport slave (
        input  req_valid, req_addr, req_char, clear_req, oled_ready,
        output req_ack, oled_command, oled_strobe, oled_wait, init_done, busy
    );

    // Requester / panel side
    modport master (
        output req_valid, req_addr, req_char, clear_req, oled_ready,
        input  req_ack, oled_command, oled_strobe, oled_wait, init_done, busy
    );
endinterface

// File: rtl/oled_text_arbiter.sv
// Character-mode command scheduler in front of the oled command port: runs the
// panel power-up sequence, then arbitrates two single-character writers and only
// sends a set-DDRAM-address when a write is not where the panel cursor already is.
module oled_text_arbiter (
    input  logic                  i_clk,
    input  logic                  i_reset,  // asynchronous, active-low
    oled_text_arbiter_if.slave    io_bus
);

    typedef enum logic [3:0] {
        StInit0, StInit1, StInit2, StInit3, StInit4,
        StIdle, StSendClear, StSendAddr, StSendData
    } state_e;

    state_e      r_state, w_state_d;
    logic [8:0]  r_cmd, w_cmd_d;
    logic        r_wait, w_wait_d;
    logic        r_strobe, w_strobe_d;
    logic [1:0]  r_ack, w_ack_d;
    logic        r_init_done, w_init_done_d;
    logic        r_clear_pending, w_clear_pending_d;
    logic        r_cur_valid, w_cur_valid_d;
    logic [6:0]  r_cursor, w_cursor_d;
    logic        r_rr, w_rr_d;          // requester favoured on a tie
    logic [6:0]  r_addr, w_addr_d;
    logic [7:0]  r_char, w_char_d;
    logic        w_issue;
    logic        w_grant;
    logic [6:0]  w_gnt_addr;

    // The panel accepts a command only when ready and not in the strobe cycle itself
    assign w_issue = io_bus.oled_ready && !r_strobe;

    // Next-state, command selection, arbitration and cursor tracking
    always_comb begin
        w_state_d         = r_state;
        w_cmd_d           = r_cmd;
        w_wait_d          = r_wait;
        w_strobe_d        = 1'b0;
        w_ack_d           = 2'b00;
        w_init_done_d     = r_init_done;
        w_clear_pending_d = r_clear_pending | io_bus.clear_req;
        w_cur_valid_d     = r_cur_valid;
        w_cursor_d        = r_cursor;
        w_rr_d            = r_rr;
        w_addr_d          = r_addr;
        w_char_d          = r_char;
        w_grant           = 1'b0;
        w_gnt_addr        = io_bus.req_addr[6:0];

        unique case (r_state)
            StInit0: if (w_issue) begin
                w_cmd_d = 9'h038; w_wait_d = 1'b1; w_strobe_d = 1'b1; w_state_d = StInit1;
            end
            StInit1: if (w_issue) begin
                w_cmd_d = 9'h00C; w_wait_d = 1'b1; w_strobe_d = 1'b1; w_state_d = StInit2;
            end
            StInit2: if (w_issue) begin
                w_cmd_d = 9'h001; w_wait_d = 1'b1; w_strobe_d = 1'b1; w_state_d = StInit3;
            end
            StInit3: if (w_issue) begin
                w_cmd_d = 9'h006; w_wait_d = 1'b1; w_strobe_d = 1'b1; w_state_d = StInit4;
            end
            StInit4: if (w_issue) begin
                w_cmd_d       = 9'h017;
                w_wait_d      = 1'b1;
                w_strobe_d    = 1'b1;
                w_init_done_d = 1'b1;
                w_cursor_d    = 7'h00;
                w_cur_valid_d = 1'b1;
                w_state_d     = StIdle;
            end
            StIdle: begin
                // A clear pulse arriving this very cycle already outranks pending writes
                if (w_clear_pending_d) begin
                    w_state_d = StSendClear;
                end else if (|io_bus.req_valid) begin
                    w_grant    = (io_bus.req_valid == 2'b11) ? r_rr : io_bus.req_valid[1];
                    w_ack_d    = w_grant ? 2'b10 : 2'b01;
                    w_rr_d     = ~w_grant;
                    w_gnt_addr = w_grant ? io_bus.req_addr[13:7] : io_bus.req_addr[6:0];
                    w_addr_d   = w_gnt_addr;
                    w_char_d   = w_grant ? io_bus.req_char[15:8] : io_bus.req_char[7:0];
                    w_state_d  = (r_cur_valid && w_gnt_addr == r_cursor) ? StSendData
                                                                          : StSendAddr;
                end
            end
            StSendClear: if (w_issue) begin
                w_cmd_d           = 9'h001;
                w_wait_d          = 1'b1;
                w_strobe_d        = 1'b1;
                // Pulses that land on the issue edge merge into this clear
                w_clear_pending_d = 1'b0;
                w_cursor_d        = 7'h00;
                w_cur_valid_d     = 1'b1;
                w_state_d         = StIdle;
            end
            StSendAddr: if (w_issue) begin
                w_cmd_d = {2'b01, r_addr}; w_wait_d = 1'b0; w_strobe_d = 1'b1;
                w_state_d = StSendData;
            end
            StSendData: if (w_issue) begin
                w_cmd_d    = {1'b1, r_char};
                w_wait_d   = 1'b0;
                w_strobe_d = 1'b1;
                // Follow the panel's auto-increment including the line wraps
                if (r_addr == 7'h27)      w_cursor_d = 7'h40;
                else if (r_addr == 7'h67) w_cursor_d = 7'h00;
                else                      w_cursor_d = r_addr + 7'd1;
                w_cur_valid_d = (r_addr <= 7'h27) || (r_addr >= 7'h40 && r_addr <= 7'h67);
                w_state_d     = StIdle;
            end
            default: w_state_d = StInit0;
        endcase
    end

    // State and output registers; reset abandons any in-flight command
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state         <= StInit0;
            r_cmd           <= 9'h000;
            r_wait          <= 1'b0;
            r_strobe        <= 1'b0;
            r_ack           <= 2'b00;
            r_init_done     <= 1'b0;
            r_clear_pending <= 1'b0;
            r_cur_valid     <= 1'b0;
            r_cursor        <= 7'h00;
            r_rr            <= 1'b0;
            r_addr          <= 7'h00;
            r_char          <= 8'h00;
        end else begin
            r_state         <= w_state_d;
            r_cmd           <= w_cmd_d;
            r_wait          <= w_wait_d;
            r_strobe        <= w_strobe_d;
            r_ack           <= w_ack_d;
            r_init_done     <= w_init_done_d;
            r_clear_pending <= w_clear_pending_d;
            r_cur_valid     <= w_cur_valid_d;
            r_cursor        <= w_cursor_d;
            r_rr            <= w_rr_d;
            r_addr          <= w_addr_d;
            r_char          <= w_char_d;
        end
    end

    assign io_bus.oled_command = r_cmd;
    assign io_bus.oled_wait    = r_wait;
    assign io_bus.oled_strobe  = r_strobe;
    assign io_bus.req_ack      = r_ack;
    assign io_bus.init_done    = r_init_done;
    assign io_bus.busy         = (r_state != StIdle);

endmodule

// File: tb/tb_oled_text_arbiter.sv
// Directed bench: a modelled oled driver toggles ready after each strobe, a
// scoreboard of expected {wait, command} words is filled as requests are driven
// and drained as strobes appear.
module tb_oled_text_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    oled_text_arbiter_if bus ();

    oled_text_arbiter dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [9:0]  exp_q[$];          // {wait, rs, db}
    logic [6:0]  m_cursor = 7'h00;
    logic        m_cur_valid = 1'b0;
    logic        m_rr = 1'b0;
    logic        hold_low = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_strobe = 1'b0;
    logic [6:0]  a0[4], a1[4];
    logic [7:0]  c0[4], c1[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Panel model: ready drops after every strobe, longer for busy-waited commands
    initial begin
        bus.oled_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (hold_low) begin
                bus.oled_ready = 1'b0;
            end else if (bus.oled_strobe) begin
                bus.oled_ready = 1'b0;
                repeat (bus.oled_wait ? 4 : 2) @(posedge clk);
                #2;
                bus.oled_ready = !hold_low;
            end else begin
                bus.oled_ready = 1'b1;
            end
        end
    end

    // Monitor: every strobe is checked against the scoreboard and the issue rule
    always @(negedge clk) begin
        logic [9:0] e;
        if (bus.oled_strobe) begin
            check("strobe_gap", 32'(prev_strobe), 32'd0);
            check("strobe_ready", 32'(prev_ready), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'({bus.oled_wait, bus.oled_command}), 'x);
            end else begin
                e = exp_q.pop_front();
                check("cmd", 32'({bus.oled_wait, bus.oled_command}), 32'(e));
                if (e == 10'h217) check("init_done_last_init", 32'(bus.init_done), 32'd1);
            end
        end
        if (bus.req_ack != 2'b00) check("ack_after_init", 32'(bus.init_done), 32'd1);
        prev_ready  <= bus.oled_ready;
        prev_strobe <= bus.oled_strobe;
    end

    task automatic push_init();
        exp_q.push_back(10'h238);
        exp_q.push_back(10'h20C);
        exp_q.push_back(10'h201);
        exp_q.push_back(10'h206);
        exp_q.push_back(10'h217);
        m_cursor    = 7'h00;
        m_cur_valid = 1'b1;
        m_rr        = 1'b0;
    endtask

    task automatic push_write(input logic [6:0] a, input logic [7:0] c);
        if (!(m_cur_valid && a == m_cursor)) exp_q.push_back({1'b0, 2'b01, a});
        exp_q.push_back({2'b01, c});
        if (a == 7'h27)      m_cursor = 7'h40;
        else if (a == 7'h67) m_cursor = 7'h00;
        else                 m_cursor = 7'(a + 7'd1);
        m_cur_valid = (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd"},    32'(bus.oled_command), 32'd0);
        check({tag, "_strobe"}, 32'(bus.oled_strobe), 32'd0);
        check({tag, "_wait"},   32'(bus.oled_wait), 32'd0);
        check({tag, "_ack"},    32'(bus.req_ack), 32'd0);
        check({tag, "_init"},   32'(bus.init_done), 32'd0);
        check({tag, "_busy"},   32'(bus.busy), 32'd1);
    endtask

    task automatic wait_ack(input logic [1:0] expv);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.req_ack != 2'b00) begin
                check("ack", 32'(bus.req_ack), 32'(expv));
                return;
            end
        end
        check("ack_timeout", 32'(bus.req_ack), 32'(expv));
    endtask

    task automatic drive_item(input logic r, input int k);
        if (!r) begin
            bus.req_addr[6:0] = a0[k];
            bus.req_char[7:0] = c0[k];
        end else begin
            bus.req_addr[13:7] = a1[k];
            bus.req_char[15:8] = c1[k];
        end
        bus.req_valid[r] = 1'b1;
    endtask

    task automatic write1(input logic r, input logic [6:0] a, input logic [7:0] c);
        if (!r) begin a0[0] = a; c0[0] = c; end
        else    begin a1[0] = a; c1[0] = c; end
        push_write(a, c);
        m_rr = ~r;
        drive_item(r, 0);
        wait_ack(r ? 2'b10 : 2'b01);
        bus.req_valid[r] = 1'b0;
        @(negedge clk);
        check("ack_pulse", 32'(bus.req_ack), 32'd0);
    endtask

    // Both requesters stay valid; items 0 must already be driven
    task automatic run_both(input int n0, input int n1);
        int   i0 = 0;
        int   i1 = 0;
        logic p;
        while (i0 < n0 || i1 < n1) begin
            p = (i0 < n0 && i1 < n1) ? m_rr : (i0 < n0 ? 1'b0 : 1'b1);
            if (p) push_write(a1[i1], c1[i1]);
            else   push_write(a0[i0], c0[i0]);
            m_rr = ~p;
            wait_ack(p ? 2'b10 : 2'b01);
            if (p) begin
                i1++;
                if (i1 < n1) drive_item(1'b1, i1); else bus.req_valid[1] = 1'b0;
            end else begin
                i0++;
                if (i0 < n0) drive_item(1'b0, i0); else bus.req_valid[0] = 1'b0;
            end
            @(negedge clk);
            check("ack_pulse_rr", 32'(bus.req_ack), 32'd0);
        end
    endtask

    task automatic wait_init();
        for (int i = 0; i < 300 && !bus.init_done; i++) @(negedge clk);
        check("init_done", 32'(bus.init_done), 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.busy && bus.oled_ready) break;
        end
        check({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle"},  32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.req_valid = 2'b00;
        bus.req_addr  = 14'h0;
        bus.req_char  = 16'h0;
        bus.clear_req = 1'b0;

        // Reset state and power-up sequence
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        push_init();
        rst_n = 1'b1;
        wait_init();
        drain("init");

        // Contiguous writes, then a jump
        write1(1'b0, 7'h00, "H");
        write1(1'b0, 7'h01, "i");
        write1(1'b0, 7'h05, "x");
        drain("contig");

        // Line wraps
        write1(1'b0, 7'h67, "c");
        write1(1'b0, 7'h00, "d");
        write1(1'b1, 7'h27, "a");
        write1(1'b1, 7'h40, "b");
        drain("wrap");

        // Round-robin with both requesters saturated; interleaved addresses stay contiguous
        for (int k = 0; k < 4; k++) begin
            a0[k] = 7'(7'h10 + 2 * k);
            a1[k] = 7'(7'h11 + 2 * k);
            c0[k] = 8'(8'h41 + k);
            c1[k] = 8'(8'h61 + k);
        end
        drive_item(1'b0, 0);
        drive_item(1'b1, 0);
        run_both(4, 4);
        drain("arb");

        // Clear outranks simultaneous requests; two pulses before service merge
        if (!m_rr) begin a0[0] = 7'h00; c0[0] = "P"; a1[0] = 7'h01; c1[0] = "Q"; end
        else       begin a1[0] = 7'h00; c1[0] = "P"; a0[0] = 7'h01; c0[0] = "Q"; end
        hold_low = 1'b1;
        repeat (6) @(negedge clk);
        drive_item(1'b0, 0);
        drive_item(1'b1, 0);
        bus.clear_req = 1'b1;
        exp_q.push_back(10'h201);
        m_cursor    = 7'h00;
        m_cur_valid = 1'b1;
        @(negedge clk) bus.clear_req = 1'b0;
        @(negedge clk) bus.clear_req = 1'b1;
        @(negedge clk) bus.clear_req = 1'b0;
        check("clear_busy", 32'(bus.busy), 32'd1);
        check("clear_no_ack", 32'(bus.req_ack), 32'd0);
        hold_low = 1'b0;
        run_both(1, 1);
        drain("clear");

        // Reset between address and data strobes
        exp_q.push_back({1'b0, 2'b01, 7'h30});
        bus.req_addr[13:7] = 7'h30;
        bus.req_char[15:8] = "Z";
        bus.req_valid[1]   = 1'b1;
        wait_ack(2'b10);
        bus.req_valid[1] = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("addr_strobe_seen", 32'(exp_q.size()), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset_hold");
        push_init();
        // Request held across init must not be acked before init completes
        write1(1'b0, 7'h00, "E");
        drain("reinit");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Release of the second reset happens while write1 is waiting for its ack
    initial begin
        wait (rst_n == 1'b1);
        wait (rst_n == 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    end

endmodule
